// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and types for the core front end.
//   FETCH_WIDTH    instructions per imem response packet
//   PIPE_WIDTH     instructions handed to the decoder per cycle
//   CPU_ADDR_BITS  address width
//   CPU_INST_BITS  instruction width
//   PC_RESET       PC loaded on reset
//   CLK_PERIOD     nominal clock period for benches
//   ib_entry_t     one instruction-buffer entry: packet PC plus packet data
package uarch_pkg;

    localparam int unsigned FETCH_WIDTH   = 2;
    localparam int unsigned PIPE_WIDTH    = FETCH_WIDTH;
    localparam int unsigned CPU_ADDR_BITS = 32;
    localparam int unsigned CPU_INST_BITS = 32;
    localparam int unsigned CLK_PERIOD    = 10;

    localparam logic [CPU_ADDR_BITS-1:0] PC_RESET = 32'h0000_0000;

    // Byte stride between consecutive fetch packets.
    localparam logic [CPU_ADDR_BITS-1:0] PACKET_BYTES = CPU_ADDR_BITS'(4 * FETCH_WIDTH);

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0]             pc;
        logic [FETCH_WIDTH*CPU_INST_BITS-1:0] insts;
    } ib_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: synchronous FIFO of ib_entry_t packets.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clear          synchronous flush of all entries (wins over push/pop)
//   push/push_data write one entry; accepted when not full, or when full and popping
//   pop/head       head entry and its removal; pop ignored when empty
//   is_empty/is_full/count  occupancy
// DEPTH must be a power of two and at least 2.
module fetch_ibuf
    import uarch_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  ib_entry_t        push_data,
    input  logic             pop,
    output ib_entry_t        head,
    output logic             is_empty,
    output logic             is_full,
    output logic [CNT_W-1:0] count
);

    ib_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign head     = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~is_empty;
    assign do_push = push & (~is_full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the head is only consumed while the buffer is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, issues one packet request per cycle to
// instruction memory, pairs in-order responses with their PCs in an instruction
// buffer, and hands PIPE_WIDTH instructions to the decoder with valid/ready.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   flush, pc_sel, rob_pc        ROB flush; pc_sel[0] loads rob_pc on flush
//   imem_req_*                   request channel (address = PC)
//   imem_rec_*                   response channel (instruction k at [32k+31:32k])
//   decoder_rdy, fetch_val       decoder handshake
//   insts, inst_pcs              buffer-head instructions and their PCs
// Optional: define FETCH_PERF_CNT_EN to add saturating perf_fetched / perf_stall.
module fetch_unit
    import uarch_pkg::*;
#(
    parameter int unsigned IB_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic [2:0]                                pc_sel,
    input  logic [CPU_ADDR_BITS-1:0]                  rob_pc,
    input  logic                                      imem_req_rdy,
    output logic                                      imem_req_val,
    output logic [CPU_ADDR_BITS-1:0]                  imem_req_packet,
    output logic                                      imem_rec_rdy,
    input  logic                                      imem_rec_val,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0]      imem_rec_packet,
    input  logic                                      decoder_rdy,
    output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  inst_pcs,
    output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  insts,
    output logic                                      fetch_val
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                               perf_fetched,
    output logic [31:0]                               perf_stall
`endif
);

    localparam int unsigned PTR_W  = $clog2(IB_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    // Responses still owed by memory for flushed requests; 8 bits covers any
    // memory with fewer than 256 requests outstanding.
    localparam int unsigned DROP_W = 8;

    logic [CPU_ADDR_BITS-1:0] pc_q, pc_d;
    logic [CPU_ADDR_BITS-1:0] infl_pc_q [IB_DEPTH];
    logic [PTR_W-1:0]         infl_wr_q, infl_rd_q;
    logic [CNT_W-1:0]         infl_cnt_q;
    logic [DROP_W-1:0]        drop_cnt_q, drop_cnt_d;
    logic [DROP_W-1:0]        outstanding;

    ib_entry_t                ib_head, ib_wdata;
    logic                     ib_empty, ib_full;
    logic [CNT_W-1:0]         ib_count;
    logic [SUM_W-1:0]         credit_used;
    logic                     req_fire, rec_fire, rec_keep, ib_pop;

    logic unused_pc_sel;
    assign unused_pc_sel = ^pc_sel[2:1];

    // Only request when every in-flight packet is guaranteed a buffer slot.
    assign credit_used     = SUM_W'(ib_count) + SUM_W'(infl_cnt_q);
    assign imem_req_val    = rst & ~flush & (credit_used < SUM_W'(IB_DEPTH));
    assign imem_req_packet = pc_q;
    assign req_fire        = imem_req_val & imem_req_rdy;

    assign imem_rec_rdy = ~ib_full;
    assign rec_fire     = imem_rec_val & imem_rec_rdy;
    // A response is kept only if it answers a live request: nothing in the flush
    // cycle, and not while responses to flushed requests are still draining.
    assign rec_keep     = rec_fire & ~flush & (drop_cnt_q == '0) & (infl_cnt_q != '0);

    assign ib_wdata.pc    = infl_pc_q[infl_rd_q];
    assign ib_wdata.insts = imem_rec_packet;

    assign fetch_val = ~ib_empty;
    assign ib_pop    = fetch_val & decoder_rdy;

    fetch_ibuf #(
        .DEPTH (IB_DEPTH)
    ) ib (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (rec_keep),
        .push_data (ib_wdata),
        .pop       (ib_pop),
        .head      (ib_head),
        .is_empty  (ib_empty),
        .is_full   (ib_full),
        .count     (ib_count)
    );

    // Outputs read zero while the buffer is empty.
    always_comb begin
        insts    = '0;
        inst_pcs = '0;
        if (!ib_empty) begin
            for (int unsigned k = 0; k < PIPE_WIDTH; k++) begin
                insts[k]    = ib_head.insts[k*CPU_INST_BITS +: CPU_INST_BITS];
                inst_pcs[k] = ib_head.pc + CPU_ADDR_BITS'(4 * k);
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (flush) begin
            if (pc_sel[0]) pc_d = rob_pc;
        end else if (req_fire) begin
            pc_d = pc_q + PACKET_BYTES;
        end
    end

    // On flush every outstanding request becomes a drop, less the one whose
    // response is consumed (and discarded) in the flush cycle itself.
    assign outstanding = drop_cnt_q + DROP_W'(infl_cnt_q);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = outstanding - DROP_W'(rec_fire && (outstanding != '0));
        end else if (rec_fire && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= PC_RESET;
            drop_cnt_q <= '0;
            infl_wr_q  <= '0;
            infl_rd_q  <= '0;
            infl_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
            if (flush) begin
                infl_wr_q  <= '0;
                infl_rd_q  <= '0;
                infl_cnt_q <= '0;
            end else begin
                if (req_fire) infl_wr_q <= infl_wr_q + PTR_W'(1);
                if (rec_keep) infl_rd_q <= infl_rd_q + PTR_W'(1);
                infl_cnt_q <= infl_cnt_q + CNT_W'(req_fire) - CNT_W'(rec_keep);
            end
        end
    end

    // req_fire never coincides with flush, so no clear guard is needed here.
    always_ff @(posedge clk) begin
        if (req_fire) infl_pc_q[infl_wr_q] <= pc_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall_now;

    assign stall_now = (fetch_val & ~decoder_rdy) | (imem_req_val & ~imem_req_rdy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (ib_pop && !flush && (perf_fetched_q != '1)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (stall_now && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, one-cycle instruction memory.
module tb_fetch_unit;
    import uarch_pkg::*;

    logic                                     clk = 1'b0;
    logic                                     rst;
    logic                                     flush;
    logic [2:0]                               pc_sel;
    logic [CPU_ADDR_BITS-1:0]                 rob_pc;
    logic                                     imem_req_rdy;
    logic                                     imem_req_val;
    logic [CPU_ADDR_BITS-1:0]                 imem_req_packet;
    logic                                     imem_rec_rdy;
    logic                                     imem_rec_val;
    logic [FETCH_WIDTH*CPU_INST_BITS-1:0]     imem_rec_packet;
    logic                                     decoder_rdy;
    logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs;
    logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts;
    logic                                     fetch_val;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]                              perf_fetched;
    logic [31:0]                              perf_stall;
`endif

    int vectors;
    int miscompares;
    logic [31:0] exp_pc;

    // Memory model state
    logic [31:0] mq[$];
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_hold;

    always #(CLK_PERIOD / 2) clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .pc_sel          (pc_sel),
        .rob_pc          (rob_pc),
        .imem_req_rdy    (imem_req_rdy),
        .imem_req_val    (imem_req_val),
        .imem_req_packet (imem_req_packet),
        .imem_rec_rdy    (imem_rec_rdy),
        .imem_rec_val    (imem_rec_val),
        .imem_rec_packet (imem_rec_packet),
        .decoder_rdy     (decoder_rdy),
        .inst_pcs        (inst_pcs),
        .insts           (insts),
        .fetch_val       (fetch_val)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // One-cycle, in-order memory: a request accepted at edge N is offered at edge N+1.
    assign imem_rec_val    = mem_valid & ~mem_hold;
    assign imem_rec_packet = {inst_of(mem_addr + 32'd4), inst_of(mem_addr)};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mem_valid <= 1'b0;
            mem_addr  <= '0;
        end else begin
            if (imem_rec_val && imem_rec_rdy) void'(mq.pop_front());
            if (imem_req_val && imem_req_rdy) mq.push_back(imem_req_packet);
            mem_valid <= (mq.size() != 0);
            mem_addr  <= (mq.size() != 0) ? mq[0] : 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Advance one clock; any packet the decoder takes at this edge must be the
    // next one in program order.
    task automatic tick();
        if (rst && !flush && fetch_val && decoder_rdy) begin
            chk("pop_pc0", inst_pcs[0], exp_pc);
            chk("pop_pc1", inst_pcs[1], exp_pc + 32'd4);
            chk("pop_inst0", insts[0], inst_of(exp_pc));
            chk("pop_inst1", insts[1], inst_of(exp_pc + 32'd4));
            exp_pc = exp_pc + 32'd8;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        exp_pc       = PC_RESET;
        rst          = 1'b0;
        flush        = 1'b0;
        pc_sel       = 3'b000;
        rob_pc       = 32'h0;
        imem_req_rdy = 1'b1;
        decoder_rdy  = 1'b1;
        mem_hold     = 1'b0;
        #1;
        chk1("rst_fetch_val", fetch_val, 1'b0);
        chk1("rst_req_val", imem_req_val, 1'b0);
        chk("rst_pc0", inst_pcs[0], 32'h0);
        chk("rst_inst0", insts[0], 32'h0);
        tick();
        tick();

        // Reset release and streaming; pc_sel[0] without flush must be ignored.
        rst = 1'b1;
        #1;
        chk1("first_req_val", imem_req_val, 1'b1);
        chk("first_req_pc", imem_req_packet, PC_RESET);
        pc_sel = 3'b001;
        rob_pc = 32'h300;
        tick();
        chk1("lat_val_e1", fetch_val, 1'b0);
        chk("req_pc_e1", imem_req_packet, 32'h8);
        tick();
        chk1("lat_val_e2", fetch_val, 1'b1);
        chk("first_pc0", inst_pcs[0], 32'h0);
        chk("first_pc1", inst_pcs[1], 32'h4);
        chk("first_inst0", insts[0], inst_of(32'h0));
        chk("first_inst1", insts[1], inst_of(32'h4));
        tick();
        chk("stream_pc_8", inst_pcs[0], 32'h8);
        tick();
        chk("stream_pc_10", inst_pcs[0], 32'h10);

        // Decoder back-pressure: outputs hold, buffer fills, requests stop.
        pc_sel = 3'b000;
        decoder_rdy = 1'b0;
        tick();
        chk("hold_pc_a", inst_pcs[0], 32'h10);
        tick();
        chk("hold_pc_b", inst_pcs[0], 32'h10);
        chk1("credit_stop", imem_req_val, 1'b0);
        tick();
        chk1("hold_val", fetch_val, 1'b1);
        chk("hold_pc_c", inst_pcs[0], 32'h10);
        chk("hold_inst", insts[0], inst_of(32'h10));
        chk1("full_req_val", imem_req_val, 1'b0);
        chk1("full_rec_rdy", imem_rec_rdy, 1'b0);
        decoder_rdy = 1'b1;
        repeat (4) tick();

        // Memory back-pressure: PC frozen, buffer drains, fetch resumes at frozen PC.
        imem_req_rdy = 1'b0;
        tick();
        chk("pc_frozen_a", imem_req_packet, 32'h48);
        repeat (4) tick();
        chk1("drained_val", fetch_val, 1'b0);
        chk("pc_frozen_b", imem_req_packet, 32'h48);
        chk1("stall_req_val", imem_req_val, 1'b1);
        imem_req_rdy = 1'b1;
        tick();
        chk1("resume_val_e1", fetch_val, 1'b0);
        tick();
        chk1("resume_val_e2", fetch_val, 1'b1);
        chk("resume_pc", inst_pcs[0], 32'h48);
        tick();

        // Flush with redirect; a response arrives in the flush cycle and is dropped.
        flush  = 1'b1;
        pc_sel = 3'b001;
        rob_pc = 32'h4;
        #1;
        chk1("flush_no_req", imem_req_val, 1'b0);
        tick();
        flush  = 1'b0;
        pc_sel = 3'b000;
        exp_pc = 32'h4;
        #1;
        chk1("flush_val_e0", fetch_val, 1'b0);
        chk("redirect_req", imem_req_packet, 32'h4);
        tick();
        chk1("flush_val_e1", fetch_val, 1'b0);
        tick();
        chk1("flush_val_e2", fetch_val, 1'b1);
        chk("redirect_pc0", inst_pcs[0], 32'h4);
        chk("redirect_pc1", inst_pcs[1], 32'h8);
        tick();

        // Flush with two responses in flight, redirecting to a wrapping PC.
        mem_hold = 1'b1;
        tick();
        chk1("hold_mem_val", fetch_val, 1'b0);
        flush  = 1'b1;
        pc_sel = 3'b001;
        rob_pc = 32'hFFFF_FFF8;
        tick();
        flush    = 1'b0;
        pc_sel   = 3'b000;
        mem_hold = 1'b0;
        exp_pc   = 32'hFFFF_FFF8;
        tick();
        chk1("drop_val_a", fetch_val, 1'b0);
        tick();
        chk1("drop_val_b", fetch_val, 1'b0);
        tick();
        chk1("post_drop_val", fetch_val, 1'b1);
        chk("post_drop_pc0", inst_pcs[0], 32'hFFFF_FFF8);
        chk("post_drop_pc1", inst_pcs[1], 32'hFFFF_FFFC);
        chk("post_drop_inst0", insts[0], inst_of(32'hFFFF_FFF8));
        tick();
        chk("wrap_pc0", inst_pcs[0], 32'h0);
        tick();

        // Reset mid-stream.
        rst = 1'b0;
        #1;
        chk1("midrst_val", fetch_val, 1'b0);
        chk1("midrst_req", imem_req_val, 1'b0);
        chk("midrst_pc0", inst_pcs[0], 32'h0);
        tick();
        tick();
        rst    = 1'b1;
        exp_pc = PC_RESET;
        #1;
        chk("rerst_req_pc", imem_req_packet, PC_RESET);
        tick();
        tick();
        chk1("rerst_val", fetch_val, 1'b1);
        chk("rerst_pc0", inst_pcs[0], PC_RESET);
        tick();
        chk("rerst_pc_next", inst_pcs[0], PC_RESET + 32'h8);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage of the out-of-order RISC-V core.
- Holds the PC and issues one FETCH_WIDTH-instruction packet request per cycle to instruction memory.
- Pairs each memory response with its PC and queues it in an instruction buffer.
- Presents PIPE_WIDTH instructions plus their PCs to the decoder with a valid/ready handshake; supports flush/redirect from the ROB.

Parameters:
- FETCH_WIDTH, 2, instructions per imem response packet.
- PIPE_WIDTH, 2, instructions presented to decoder per cycle (equals FETCH_WIDTH).
- CPU_ADDR_BITS, 32, address width.
- CPU_INST_BITS, 32, instruction width.
- PC_RESET, 32'h0, reset PC.
- IB_DEPTH, 4, instruction-buffer entries (packets); power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered and in-flight fetches.
- pc_sel  in  3  next-PC select; bit0 = ROB redirect; bits 2:1 reserved (ignored).
- rob_pc  in  CPU_ADDR_BITS  redirect target.
- imem_req_rdy  in  1  memory can accept a request.
- imem_req_val  out  1  request valid.
- imem_req_packet  out  CPU_ADDR_BITS  fetch address (word aligned).
- imem_rec_rdy  out  1  fetch can accept a response.
- imem_rec_val  in  1  response valid.
- imem_rec_packet  in  FETCH_WIDTH*CPU_INST_BITS  instruction k at bits [32k+31:32k].
- decoder_rdy  in  1  decoder accepts the current output.
- inst_pcs  out  PIPE_WIDTH x CPU_ADDR_BITS  PC of each output instruction.
- insts  out  PIPE_WIDTH x CPU_INST_BITS  output instructions.
- fetch_val  out  1  inst_pcs/insts valid.

Behaviour:
- Reset (rst=0, async):
  - PC = PC_RESET; buffer and in-flight queue empty; drop counter 0.
  - Outputs fetch_val=0, imem_req_val=0, insts/inst_pcs=0.
- Request issue:
  - imem_req_val=1 when rst released, flush=0, and ib_count + inflight < IB_DEPTH.
  - imem_req_packet = PC.
  - Handshake fires on imem_req_val & imem_req_rdy; then PC <= PC + 4*FETCH_WIDTH and the PC is pushed to the in-flight PC queue (depth IB_DEPTH).
  - imem_req_rdy=0 holds PC; no request is lost.
- Response:
  - imem_rec_rdy = !ib_full.
  - On imem_rec_val & imem_rec_rdy, pop the in-flight PC and write {pc, insts} into the buffer.
  - If drop counter > 0, decrement it and discard the response instead.
  - Memory returns responses in order.
- Output:
  - The buffer head drives outputs; inst_pcs[k] = head_pc + 4k; fetch_val = !ib_empty.
  - Pop on fetch_val & decoder_rdy.
  - While decoder_rdy=0, outputs hold stable.
  - Simultaneous push and pop is allowed when full or empty.
  - No combinational bypass: a response appears at the outputs the cycle after it is written.
- Flush (sampled at posedge):
  - Buffer cleared; in-flight queue cleared; drop counter <= outstanding in-flight count minus any response accepted this cycle.
  - Any response arriving in the flush cycle is dropped.
  - If pc_sel[0]=1, PC <= rob_pc; else PC unchanged.
  - No request is issued in the flush cycle.
- Redirect latency (1-cycle memory): at flush edge E0, PC=target; request accepted at E1; response written at E2; after E2, inst_pcs[0]=target and fetch_val=1.
- pc_sel[0] without flush is ignored.
- PC wraps modulo 2^CPU_ADDR_BITS.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetched (32b, counts buffer pops) and perf_stall (32b, counts cycles with fetch_val & !decoder_rdy, or imem_req_val & !imem_req_rdy). Both reset to 0, saturate at max.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- uarch_pkg holds FETCH_WIDTH, PIPE_WIDTH, CPU_ADDR_BITS, CPU_INST_BITS, PC_RESET, CLK_PERIOD, and an ib_entry_t struct {pc, insts}.
- One sub-module, fetch_ibuf: a synchronous FIFO of ib_entry_t with push/pop, clear, is_empty, is_full, and count. It is instantiated as ib.

Test Plan:
- Reset release with 1-cycle memory and decoder_rdy=1 -> first output PC 0x0 then 0x8, 0x10, ...; inst_pcs[1]=inst_pcs[0]+4; insts match the hex image.
- decoder_rdy=0 for 3 cycles -> outputs and fetch_val held constant; buffer fills to IB_DEPTH; imem_req_val drops; after release, PCs continue with no gap or duplicate.
- imem_req_rdy=0 for 5 cycles -> PC frozen; buffer drains to empty and fetch_val=0; after release, fetching resumes at the frozen PC.
- flush=1 with pc_sel=3'b001, rob_pc=0x4 -> two cycles after the flush edge inst_pcs[0]=0x4, inst_pcs[1]=0x8; no pre-flush PC is ever output.
- flush with 2 responses in flight -> both dropped; the first output after the flush is the redirect target.
- rst asserted mid-stream -> fetch_val=0 immediately; the first fetch after release is at PC_RESET.
